valrdy_queue: RTL and testbench

- Parametrised FIFO queue with val/rdy handshakes on both sides.
- Storage is DEPTH entries of BITWIDTH-bit enabled registers with synchronous reset, generalising the single enabled register to a multi-entry buffer.
- Sits between a val/rdy producer and consumer to decouple stalls and absorb bursts of up to DEPTH messages.

---
 rtl/valrdy_queue.sv | 75 +++++++
 tb/tb_valrdy_queue.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/valrdy_queue.sv
// Parametrised val/rdy FIFO queue built from DEPTH enabled registers.
// Define VALRDYQUEUE_BYPASS_EN for a same-cycle empty-queue bypass path.
module valrdy_queue #(
  parameter int BITWIDTH = 32,
  parameter int DEPTH    = 4
) (
  input  logic                         CLK,
  input  logic                         RESET,
  input  logic                         recv_val,
  output logic                         recv_rdy,
  input  logic [BITWIDTH-1:0]          recv_msg,
  output logic                         send_val,
  input  logic                         send_rdy,
  output logic [BITWIDTH-1:0]          send_msg,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH-1);

  logic [BITWIDTH-1:0] entry [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       cnt;
  logic                empty;
  logic                enq;
  logic                deq;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign empty    = (cnt == '0);
  assign recv_rdy = (cnt != FULL);
  assign count    = cnt;
  assign deq      = !empty && send_rdy;

`ifdef VALRDYQUEUE_BYPASS_EN
  logic byp;
  assign byp      = empty && recv_val;
  assign send_val = !empty || byp;
  assign send_msg = byp ? recv_msg : entry[head];
  // A bypassed message that is consumed immediately is never stored.
  assign enq      = recv_val && recv_rdy && !(byp && send_rdy);
`else
  assign send_val = !empty;
  assign send_msg = entry[head];
  assign enq      = recv_val && recv_rdy;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
      for (int i = 0; i < DEPTH; i++)
        entry[i] <= '0;
    end else begin
      if (enq) begin
        entry[tail] <= recv_msg;
        tail        <= nxt(tail);
      end
      if (deq)
        head <= nxt(head);
      if (enq && !deq)
        cnt <= cnt + CW'(1);
      else if (deq && !enq)
        cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: tb/tb_valrdy_queue.sv
// Scoreboard bench for valrdy_queue: DEPTH=4 and DEPTH=3 instances
// share stimulus and are checked against per-instance FIFO models.
module tb_valrdy_queue;

`ifdef VALRDYQUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        recv_val = 1'b0;
  logic [31:0] recv_msg = '0;
  logic        send_rdy = 1'b0;

  logic        rrdy4, sval4;
  logic [31:0] smsg4;
  logic [2:0]  cnt4;
  logic        rrdy3, sval3;
  logic [31:0] smsg3;
  logic [1:0]  cnt3;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [31:0] q4[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  valrdy_queue #(.BITWIDTH(32), .DEPTH(4)) u4 (
    .CLK(clk), .RESET(RESET),
    .recv_val(recv_val), .recv_rdy(rrdy4), .recv_msg(recv_msg),
    .send_val(sval4), .send_rdy(send_rdy), .send_msg(smsg4),
    .count(cnt4)
  );

  valrdy_queue #(.BITWIDTH(32), .DEPTH(3)) u3 (
    .CLK(clk), .RESET(RESET),
    .recv_val(recv_val), .recv_rdy(rrdy3), .recv_msg(recv_msg),
    .send_val(sval3), .send_rdy(send_rdy), .send_msg(smsg3),
    .count(cnt3)
  );

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(int k);
    return (k == 0) ? q4.size() : q3.size();
  endfunction

  function automatic logic [31:0] qfront(int k);
    return (k == 0) ? q4[0] : q3[0];
  endfunction

  task automatic qpop(int k);
    if (k == 0) void'(q4.pop_front());
    else        void'(q3.pop_front());
  endtask

  task automatic qpush(int k, logic [31:0] v);
    if (k == 0) q4.push_back(v);
    else        q3.push_back(v);
  endtask

  // Compare one instance against its model, then retire a consumed entry.
  task automatic mon(int k, int d, logic [31:0] c, logic rr,
                     logic sv, logic [31:0] sm);
    int n;
    logic pass;
    n = qsize(k);
    pass = BYP && (n == 0) && recv_val;
    chk($sformatf("count_d%0d", d), c, n);
    chk($sformatf("recv_rdy_d%0d", d), {31'b0, rr}, {31'b0, n != d});
    chk($sformatf("send_val_d%0d", d), {31'b0, sv},
        {31'b0, (n != 0) || pass});
    if (pass)
      chk($sformatf("bypass_msg_d%0d", d), sm, recv_msg);
    else if (n != 0)
      chk($sformatf("send_msg_d%0d", d), sm, qfront(k));
    if (n != 0 && send_rdy)
      qpop(k);
  endtask

  always @(negedge clk) begin
    #2;
    if (mon_en && !RESET) begin
      mon(0, 4, {29'b0, cnt4}, rrdy4, sval4, smsg4);
      mon(1, 3, {30'b0, cnt3}, rrdy3, sval3, smsg3);
    end
  end

  // Drive one cycle; expected stored messages are pushed after the
  // monitor has looked at this cycle's outputs.
  task automatic cycle(logic rv, logic [31:0] msg, logic sr, logic rst);
    bit e4, e3;
    @(negedge clk);
    RESET    = rst;
    recv_val = rv;
    recv_msg = msg;
    send_rdy = sr;
    e4 = !rst && rv && (q4.size() != 4) && !(BYP && q4.size() == 0 && sr);
    e3 = !rst && rv && (q3.size() != 3) && !(BYP && q3.size() == 0 && sr);
    #3;
    if (rst) begin
      q4.delete();
      q3.delete();
    end else begin
      if (e4) qpush(0, msg);
      if (e3) qpush(1, msg);
    end
  endtask

  task automatic do_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset();
    mon_en = 1'b1;
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("reset_send_msg_d4", smsg4, 32'h0);
    chk("reset_send_msg_d3", smsg3, 32'h0);
    chk("reset_send_val_d4", {31'b0, sval4}, 32'h0);
    chk("reset_recv_rdy_d4", {31'b0, rrdy4}, 32'h1);

    for (int i = 0; i < 4; i++)
      cycle(1'b1, 32'hA0 + i, 1'b0, 1'b0);
    cycle(1'b1, 32'hFF, 1'b0, 1'b0);
    chk("full_count_d4", {29'b0, cnt4}, 32'd4);
    chk("full_recv_rdy_d4", {31'b0, rrdy4}, 32'h0);
    cycle(1'b1, 32'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("drained_count_d4", {29'b0, cnt4}, 32'd0);

    do_reset();
    cycle(1'b1, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 32'h2, 1'b0, 1'b0);
    for (int v = 3; v <= 9; v++)
      cycle(1'b1, v, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("wrap_count_d3", {30'b0, cnt3}, 32'd2);
    chk("wrap_head_d3", smsg3, 32'h8);
    chk("wrap_head_d4", smsg4, 32'h8);

    do_reset();
    cycle(1'b1, 32'h55, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 32'h0, 1'b0, 1'b0);
      chk("hold_msg_d4", smsg4, 32'h55);
    end

    cycle(1'b1, 32'h66, 1'b0, 1'b0);
    cycle(1'b1, 32'h67, 1'b0, 1'b0);
    cycle(1'b1, 32'hEE, 1'b1, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("midreset_count_d4", {29'b0, cnt4}, 32'd0);
    chk("midreset_send_val_d4", {31'b0, sval4}, 32'h0);

    cycle(1'b1, 32'h77, 1'b1, 1'b0);
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    chk("after_77_count_d4", {29'b0, cnt4}, BYP ? 32'd0 : 32'd1);

    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0);
    for (int i = 0; i < 6; i++)
      cycle(1'b0, 32'h0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
